// File: rtl/rx_line_fetch_ctrl.sv
// Read-side line sequencer for the receive video FIFO: drops stale entries, streams the
// requested line and pads missing pixels so every request yields exactly PIX_PER_LINE words.
module rx_line_fetch_ctrl #(
  parameter int          PIX_PER_LINE = 1280,
  parameter int          TIMEOUT      = 200,
  parameter logic [15:0] PAD_VALUE    = 16'h8010
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        line_req,
  input  logic [10:0] line_num,
  input  logic [28:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        line_done,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0] PIX_LAST = 11'(PIX_PER_LINE - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEEK, STREAM, PAD, DONE} state_t;

  state_t      state;
  logic [10:0] target;
  logic [10:0] cnt;
  logic [7:0]  tmo;
  logic [10:0] diff;
  logic        head_match;
  logic        head_behind;
  logic        pop_drop;
  logic        pop_data;

  // Reserved and segment bits carry nothing this sequencer needs.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^fifo_dout[28:27];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Age of the head entry relative to the requested line, modulo the 2048-line space.
  always_comb begin
    diff        = target - fifo_dout[26:16];
    head_match  = (diff == 11'd0);
    head_behind = !diff[10] && !head_match;
    pop_drop    = (state == SEEK) && !fifo_empty && head_behind;
    pop_data    = (state == STREAM) && !fifo_empty && head_match;
    fifo_rd_en  = sys_rst_n && (pop_drop || pop_data);
  end

  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      target    <= '0;
      cnt       <= '0;
      tmo       <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      line_done <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pix_valid <= 1'b0;
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (line_req) begin
            target   <= line_num;
            cnt      <= '0;
            tmo      <= '0;
            underrun <= 1'b0;
            busy     <= 1'b1;
            state    <= SEEK;
          end
        end
        SEEK: begin
          if (fifo_empty) begin
            if (tmo == TMO_LAST) state <= PAD;
            else                 tmo   <= tmo + 8'd1;
          end else if (head_behind) begin
            drop_cnt <= sat_inc(drop_cnt);
            tmo      <= '0;
          end else if (head_match) begin
            tmo   <= '0;
            state <= STREAM;
          end else begin
            // Entry belongs to a later line; leave it in the FIFO.
            state <= PAD;
          end
        end
        STREAM: begin
          if (fifo_empty) begin
            if (tmo == TMO_LAST) state <= PAD;
            else                 tmo   <= tmo + 8'd1;
          end else if (head_match) begin
            pix_data  <= fifo_dout[15:0];
            pix_valid <= 1'b1;
            cnt       <= cnt + 11'd1;
            tmo       <= '0;
            if (cnt == PIX_LAST) state <= DONE;
          end else begin
            state <= PAD;
          end
        end
        PAD: begin
          pix_data  <= PAD_VALUE;
          pix_valid <= 1'b1;
          cnt       <= cnt + 11'd1;
          underrun  <= 1'b1;
          if (cnt == PIX_LAST) state <= DONE;
        end
        DONE: begin
          line_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_line_fetch_ctrl.sv
// Directed bench for rx_line_fetch_ctrl: a queue-backed FWFT FIFO model feeds the DUT and
// every captured pixel word is compared against hand-derived expectations.
module tb_rx_line_fetch_ctrl;

  localparam int          PPL = 1280;
  localparam logic [15:0] PADV = 16'h8010;

  logic        clk125 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        line_req = 1'b0;
  logic [10:0] line_num = '0;
  logic [28:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        line_done;
  logic        busy;
  logic        underrun;
  logic [15:0] drop_cnt;

  rx_line_fetch_ctrl dut (
    .clk125    (clk125),
    .sys_rst_n (sys_rst_n),
    .line_req  (line_req),
    .line_num  (line_num),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .line_done (line_done),
    .busy      (busy),
    .underrun  (underrun),
    .drop_cnt  (drop_cnt)
  );

  always #4 clk125 = ~clk125;

  logic [28:0] q[$];
  logic [15:0] cap[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int pop_empty_cnt = 0;
  int qs = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: pop on the edge if requested, refresh the FIFO head, sample outputs mid-cycle.
  task automatic tick();
    @(posedge clk125);
    cyc++;
    if (fifo_rd_en && q.size() > 0) void'(q.pop_front());
    fifo_empty <= (q.size() == 0);
    fifo_dout  <= (q.size() > 0) ? q[0] : 29'd0;
    @(negedge clk125);
    if (pix_valid) begin
      if (cap.size() == 0) first_cyc = cyc;
      cap.push_back(pix_data);
      last_cyc = cyc;
    end
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_rd_en && fifo_empty) pop_empty_cnt++;
  endtask

  task automatic push(input int y, input int n, input int base, input logic [1:0] top);
    for (int i = 0; i < n; i++) q.push_back({top, 11'(y), 16'(base + i)});
  endtask

  task automatic clear_mon();
    cap.delete();
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
  endtask

  task automatic request(input int line);
    line_req = 1'b1;
    line_num = 11'(line);
    req_cyc  = cyc;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic cmp_data(input string tag, input int from, input int n, input int base);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++)
      if (from + i >= cap.size() || cap[from + i] != 16'(base + i)) errs++;
    chk(tag, errs, 0);
  endtask

  task automatic cmp_pad(input string tag, input int from, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++)
      if (from + i >= cap.size() || cap[from + i] != PADV) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    int n;
    int d0;

    repeat (3) tick();
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(line_done), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_data", int'(pix_data), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    sys_rst_n = 1'b1;
    tick();

    // Full matching line already buffered.
    push(5, PPL, 0, 2'b00);
    tick();
    clear_mon();
    request(5);
    wait_done("l5_done", 2000);
    chk("l5_count", cap.size(), PPL);
    cmp_data("l5_data", 0, PPL, 0);
    chk("l5_latency", first_cyc - req_cyc, 3);
    chk("l5_no_gaps", last_cyc - first_cyc, PPL - 1);
    chk("l5_done_pos", done_cyc, last_cyc + 1);
    chk("l5_underrun", int'(underrun), 0);
    chk("l5_busy", int'(busy), 0);

    // Stale line in front of the requested one.
    push(3, 10, 5000, 2'b00);
    push(4, PPL, 100, 2'b11);
    tick();
    clear_mon();
    request(4);
    wait_done("l4_done", 2500);
    chk("l4_drops", int'(drop_cnt), 10);
    chk("l4_count", cap.size(), PPL);
    cmp_data("l4_data", 0, PPL, 100);
    chk("l4_underrun", int'(underrun), 0);

    // Partial line, then the FIFO runs dry and padding fills the rest.
    push(7, 600, 0, 2'b00);
    tick();
    clear_mon();
    request(7);
    wait_done("l7_done", 3000);
    chk("l7_count", cap.size(), PPL);
    cmp_data("l7_data", 0, 600, 0);
    cmp_pad("l7_pad", 600, PPL - 600);
    chk("l7_underrun", int'(underrun), 1);

    // Head belongs to a later line: pad without popping, then deliver it on request.
    push(8, 5, 16'h0800, 2'b00);
    tick();
    clear_mon();
    request(7);
    wait_done("ahead_done", 2000);
    chk("ahead_count", cap.size(), PPL);
    cmp_pad("ahead_pad", 0, PPL);
    chk("ahead_kept", q.size(), 5);
    chk("ahead_underrun", int'(underrun), 1);
    chk("ahead_drops", int'(drop_cnt), 10);
    clear_mon();
    request(8);
    wait_done("l8_done", 3000);
    chk("l8_count", cap.size(), PPL);
    cmp_data("l8_data", 0, 5, 16'h0800);
    cmp_pad("l8_pad", 5, PPL - 5);
    chk("l8_fifo_empty", q.size(), 0);

    // Wrap-around drop of y=2047 for line 0, plus an ignored request mid-line.
    push(2047, 3, 7, 2'b00);
    push(0, PPL, 2000, 2'b00);
    tick();
    clear_mon();
    request(0);
    chk("l0_underrun_clr", int'(underrun), 0);
    repeat (40) tick();
    request(9);
    wait_done("l0_done", 2500);
    chk("l0_drops", int'(drop_cnt), 13);
    chk("l0_count", cap.size(), PPL);
    cmp_data("l0_data", 0, PPL, 2000);
    chk("l0_underrun", int'(underrun), 0);
    d0 = done_cnt;
    repeat (50) tick();
    chk("l0_no_relatch", cap.size(), PPL);
    chk("l0_no_extra_done", done_cnt - d0, 0);
    chk("l0_busy", int'(busy), 0);

    // Reset in the middle of a line.
    push(1, PPL, 0, 2'b00);
    tick();
    clear_mon();
    request(1);
    n = 0;
    while (cap.size() < 300 && n < 1000) begin
      tick();
      n++;
    end
    chk("mid_reached", int'(cap.size() >= 300), 1);
    sys_rst_n = 1'b0;
    qs = q.size();
    d0 = done_cnt;
    tick();
    chk("mid_valid", int'(pix_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(line_done), 0);
    chk("mid_underrun", int'(underrun), 0);
    chk("mid_drop", int'(drop_cnt), 0);
    chk("mid_data", int'(pix_data), 0);
    chk("mid_rd_en", int'(fifo_rd_en), 0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_no_pops", q.size(), qs);
    chk("mid_no_line_done", done_cnt - d0, 0);
    push(2, PPL, 16'h5000, 2'b00);
    tick();
    clear_mon();
    request(2);
    wait_done("post_done", 4000);
    chk("post_drops", int'(drop_cnt), qs);
    chk("post_count", cap.size(), PPL);
    cmp_data("post_data", 0, PPL, 16'h5000);
    chk("post_underrun", int'(underrun), 0);

    chk("pop_while_empty", pop_empty_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
